// File: rtl/adc_fmt_pkg.sv
// adc_fmt_pkg: shared encodings, polarity constants and lane-reorder helper
package adc_fmt_pkg;
  typedef enum logic [1:0] {CH1 = 2'b00, CH2 = 2'b01, CH4 = 2'b10} ch_mode_e;
  typedef enum logic [1:0] {PAT_ADC = 2'b00, PAT_RAMP = 2'b01, PAT_FIXED = 2'b10} pat_e;
  localparam logic [7:0] POL_XOR_NORM = 8'h7F;
  localparam logic [7:0] POL_XOR_INV = 8'h80;
  function automatic int lane_idx(input int j, input int c, input int lanes);
    return (j % c) * (lanes / c) + j / c;
  endfunction
endpackage

// File: rtl/adc_lane_formatter_ctrl_sync.sv
// ctrl_sync: multi-flop synchroniser for slow control fields
module ctrl_sync #(
  parameter int W = 2,
  parameter int STAGES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES*W-1:0] sr;
  // shift chain, newest sample enters at the bottom
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[(STAGES-1)*W-1:0], d};
  assign q = sr[STAGES*W-1 -: W];
endmodule

// File: rtl/adc_lane_formatter.sv
// adc_lane_formatter: lane format/reorder, test patterns and beat packing
module adc_lane_formatter
  import adc_fmt_pkg::*;
#(
  parameter int LANES = 8,
  parameter int PACK = 2,
  parameter logic [LANES-1:0] LANE_POL_INV = 8'b0000_0100,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [LANES*8-1:0]      in_data,
  input  logic [1:0]              ch_mode,
  input  logic [1:0]              pat_sel,
  output logic [LANES*8*PACK-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic [1:0]              active_mode
);
  localparam int BW = LANES * 8;
  localparam int CW = PACK > 1 ? $clog2(PACK) : 1;
  logic [1:0] ch_mode_s, pat_sel_s, mode_use;
  logic [CW-1:0] pack_cnt, nxt_cnt;
  logic [BW-1:0] fmt, beat_c, s1_data;
  logic [BW*PACK-1:0] pack_buf, word_c;
  logic [7:0] ramp_cnt;
  logic s1_valid, accept, last, word_done;

  ctrl_sync #(.W(2), .STAGES(SYNC_STAGES)) u_ch_sync (.clk(clk), .rst(rst), .d(ch_mode), .q(ch_mode_s));
  ctrl_sync #(.W(2), .STAGES(SYNC_STAGES)) u_pat_sync (.clk(clk), .rst(rst), .d(pat_sel), .q(pat_sel_s));

  // nxt_cnt==0 marks a word boundary: a beat accepted then starts a new word and may take the new mode
  always_comb begin
    accept = in_valid && en;
    last = pack_cnt == CW'(PACK - 1);
    word_done = en && s1_valid && last;
    nxt_cnt = !s1_valid ? pack_cnt : last ? '0 : pack_cnt + 1'b1;
    mode_use = nxt_cnt == '0 ? ch_mode_s : active_mode;
    word_c = pack_buf;
    word_c[(PACK-1)*BW +: BW] = s1_data;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign fmt[8*i +: 8] = in_data[8*i +: 8] ^ (LANE_POL_INV[i] ? POL_XOR_INV : POL_XOR_NORM);
  end

  for (genvar j = 0; j < LANES; j++) begin : g_byte
    localparam int L2 = lane_idx(j, 2, LANES);
    localparam int L4 = lane_idx(j, 4, LANES);
    assign beat_c[8*j +: 8] = pat_sel_s == PAT_RAMP  ? ramp_cnt :
                              pat_sel_s == PAT_FIXED ? 8'(j * 17) :
                              mode_use == CH1        ? fmt[8*j +: 8] :
                              mode_use == CH2        ? fmt[8*L2 +: 8] : fmt[8*L4 +: 8];
  end

  // stage-1 beat register, pack buffer, ramp source and mode boundary tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      pack_cnt <= '0;
      pack_buf <= '0;
      ramp_cnt <= '0;
      active_mode <= CH1;
    end else begin
      if (accept) s1_data <= beat_c;
      if (accept) ramp_cnt <= ramp_cnt + 8'd1;
      s1_valid <= accept;
      pack_cnt <= en ? nxt_cnt : '0;
      if (nxt_cnt == '0 || !en) active_mode <= ch_mode_s;
      for (int k = 0; k < PACK; k++)
        if (en && s1_valid && pack_cnt == CW'(k)) pack_buf[k*BW +: BW] <= s1_data;
    end

  // output register: hold until accepted, drop and flag a word that finds it occupied
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (word_done && (!out_valid || out_ready)) begin
        out_data <= word_c;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      overflow <= (word_done && out_valid && !out_ready) || (overflow && !overflow_clr);
    end
endmodule

// File: tb/tb_adc_lane_formatter.sv
// tb_adc_lane_formatter: directed checks of format, reorder, patterns, packing and handshake
module tb_adc_lane_formatter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, out_ready = 1'b0, overflow_clr = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0] ch_mode = 2'b00, pat_sel = 2'b00;
  logic [127:0] out_data;
  logic out_valid, overflow;
  logic [1:0] active_mode;
  int errs = 0, checks = 0, w;
  logic [7:0] rb;

  localparam logic [63:0] A  = 64'h0001_0203_0405_0607;
  localparam logic [63:0] B  = 64'h0706_0504_0302_0100;
  localparam logic [63:0] A1 = 64'h7F7E_7D7C_7B85_7978;
  localparam logic [63:0] A2 = 64'h7F7B_7E85_7D79_7C78;
  localparam logic [63:0] B1 = 64'h7879_7A7B_7C82_7E7F;
  localparam logic [63:0] B2 = 64'h787C_7982_7A7E_7B7F;
  localparam logic [63:0] B4 = 64'h787A_7C7E_797B_827F;
  localparam logic [63:0] FX = 64'h7766_5544_3322_1100;

  always #5 clk = ~clk;

  adc_lane_formatter dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .ch_mode(ch_mode), .pat_sel(pat_sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .overflow_clr(overflow_clr), .active_mode(active_mode)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    in_data = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic word(input logic [63:0] lo, input logic [63:0] hi);
    beat(lo);
    beat(hi);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_data", out_data, '0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_mode", active_mode, 0);
    rst = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    // 1ch ADC: latency t+2
    word(A, A);
    chk("lat_t1", out_valid, 0);
    step();
    chk("lat_t2", out_valid, 1);
    chk("fmt_1ch", out_data, {A1, A1});
    step();
    chk("consumed", out_valid, 0);
    // overflow: three words into a stalled output
    out_ready = 1'b0;
    word(A, A);
    step();
    word(B, B);
    word(B, B);
    step();
    chk("ovf_hold_v", out_valid, 1);
    chk("ovf_hold_d", out_data, {A1, A1});
    chk("ovf_set", overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    out_ready = 1'b1;
    step();
    chk("ovf_drain", out_valid, 0);
    out_ready = 1'b0;
    word(A, A);
    step();
    word(B, B);
    out_ready = 1'b1;
    step();
    chk("swap_v", out_valid, 1);
    chk("swap_d", out_data, {B1, B1});
    chk("swap_ovf", overflow, 0);
    step();
    chk("swap_drain", out_valid, 0);
    // 4ch: fixed pattern then ADC reorder
    ch_mode = 2'b10;
    pat_sel = 2'b10;
    repeat (5) step();
    chk("mode4", active_mode, 2'b10);
    word(A, A);
    step();
    chk("fixed", out_data, {FX, FX});
    pat_sel = 2'b00;
    repeat (4) step();
    word(B, B);
    step();
    chk("fmt_4ch", out_data, {B4, B4});
    // mode change mid-word
    beat(B);
    ch_mode = 2'b01;
    repeat (5) step();
    chk("mode_pend", active_mode, 2'b10);
    beat(B);
    step();
    chk("mode_old_v", out_valid, 1);
    chk("mode_old_d", out_data, {B4, B4});
    chk("mode_new", active_mode, 2'b01);
    word(B, B);
    step();
    chk("fmt_2ch", out_data, {B2, B2});
    // en drop discards a partial word
    beat(B);
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    chk("en_partial", out_valid, 0);
    word(A, A);
    step();
    chk("en_next_v", out_valid, 1);
    chk("en_next_d", out_data, {A2, A2});
    // asynchronous reset mid-word
    beat(A);
    #3 rst = 1'b1;
    #1;
    chk("arst_data", out_data, '0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_mode", active_mode, 0);
    repeat (2) step();
    rst = 1'b0;
    pat_sel = 2'b01;
    repeat (4) step();
    chk("arst_nopart", out_valid, 0);
    // 2ch ramp, 260 beats streamed back-to-back
    repeat (5) step();
    w = 0;
    fork
      begin
        in_valid = 1'b1;
        repeat (260) step();
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 275; c++) begin
          step();
          if (out_valid) begin
            rb = 8'(2 * w);
            chk("ramp", out_data, {{8{rb + 8'd1}}, {8{rb}}});
            w++;
          end
        end
      end
    join
    chk("ramp_words", 128'(w), 128'd130);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/adc_lane_formatter.md
Name: adc_lane_formatter

Overview:
- Parametrised successor to the fixed 8-lane sample-formatting path between the ADC serdes and adc_to_datamover.
- Converts each deserialised 8-bit lane to two's complement with a per-lane polarity mask, and reorders lanes per channel mode (1/2/4 channels).
- Optionally substitutes test patterns, then packs PACK beats into one wide output word with a valid/ready handshake.
- Runs in the serdes divclk domain. The channel-mode and pattern controls arrive from the AXI GPIO domain and are synchronised internally.

Parameters:
- LANES, 8, number of 8-bit ADC lanes per beat; must be a multiple of 4.
- PACK, 2, input beats per output word; 1..8.
- LANE_POL_INV, 8'b0000_0100, per-lane bit; 1 = lane wired with inverted polarity.
- SYNC_STAGES, 3, flops in each control synchroniser; minimum 2.

Ports:
- clk  in  1  divclk; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  acquisition enable; synchronous to clk.
- in_valid  in  1  in_data beat valid.
- in_data  in  LANES*8  raw deserialised lanes; lane i = bits [8i+7:8i].
- ch_mode  in  2  asynchronous; 00 = 1ch, 01 = 2ch, 1x = 4ch.
- pat_sel  in  2  asynchronous; 00 = ADC data, 01 = ramp, 10 = fixed, 11 = ADC data.
- out_data  out  LANES*8*PACK  packed word; first beat in the LSBs.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- overflow  out  1  sticky; a packed word was dropped.
- overflow_clr  in  1  synchronous clear of overflow.
- active_mode  out  2  channel mode currently applied.

Behaviour:
- Reset values: out_data=0, out_valid=0, overflow=0, active_mode=00. Pack counter, ramp counter and synchroniser flops are also 0.
- Control synchronisation: ch_mode and pat_sel pass through SYNC_STAGES flops each. Only the synchronised copies are used.
- Accepted beat: in_valid && en. All other cycles are ignored and change no state.
- Stage 1, registered on each accepted beat:
  - Format: lane i = in_data lane i XOR (LANE_POL_INV[i] ? 8'h80 : 8'h7F).
  - Reorder: with C = channel count of active_mode, output byte j = formatted lane (j mod C)*(LANES/C) + (j div C), for j = 0..LANES-1. In 1ch mode this is the identity.
  - Pattern substitution (replaces the formatted+reordered beat):
    - Ramp: every byte = ramp_cnt. ramp_cnt is 8 bits, increments per accepted beat, wraps 8'hFF -> 8'h00.
    - Fixed: byte j = j*8'h11 (mod 256).
- Packer:
  - Stage-1 beat k (k = pack counter, 0..PACK-1) is written to slice k of the pack buffer.
  - On k = PACK-1 the counter returns to 0 and the full buffer transfers to out_data in the next cycle.
  - Latency: accepted final beat at cycle t -> out_valid high at t+2.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready.
  - If the output register is still occupied (out_valid && !out_ready) when a new word completes, the new word is dropped, overflow is set, and the held word is kept.
  - If out_ready is high in the same cycle a new word arrives, the held word completes and the new word loads; this is not an overflow.
- Mode change: a new synchronised ch_mode updates active_mode only when the pack counter is 0 and no stage-1 beat is pending. Otherwise it stays pending until that boundary, so a word never mixes modes. pat_sel takes effect immediately.
- en deassert: the pack counter and stage 1 are cleared and a partial word is discarded. A word already in the output register is still delivered.
- overflow_clr together with a new overflow event: set wins.
- Asynchronous rst mid-word: everything returns to reset values at once. No partial word is emitted.

Decomposition:
- Shared package adc_fmt_pkg holds:
  - ch_mode encodings CH1/CH2/CH4 and pattern encodings PAT_ADC/PAT_RAMP/PAT_FIXED.
  - POL_XOR_NORM = 8'h7F and POL_XOR_INV = 8'h80.
  - A function returning the lane index for (j, C, LANES).
- One sub-module, ctrl_sync: a SYNC_STAGES-deep, width-parametrised synchroniser, instantiated for ch_mode and pat_sel.

Test Plan:
- Reset; LANES=8, PACK=2, mode 1ch, pat ADC, in_data=64'h0001_0203_0405_0607 for 2 beats, out_ready=1 -> out_valid at t+2; each byte XOR 7F, byte 2 (lane 2) XOR 80. Low word = 64'h7F7E_7D7C_7B7A_7978 with byte 2 replaced by 8'h85.
- Mode 4ch, pat fixed -> every beat = 64'h7766_5544_3322_1100 (pattern bypasses reorder); then pat ADC with lane i = i -> formatted lane order from the LSB = 0,2,4,6,1,3,5,7.
- Mode 2ch, pat ramp for 260 beats -> consecutive out_data slices increment by 1 and wrap FF -> 00 with no gap.
- out_ready=0 for 3 word completions -> first word held stable, overflow=1; overflow_clr clears it; with out_ready high on the completion cycle, overflow stays 0.
- Change ch_mode after beat 0 of a PACK=2 word -> the current word completes in the old mode; active_mode updates after that word; the next word uses the new ordering.
- Drop en after 1 beat; also assert rst mid-word -> no out_valid for the partial word; all outputs return to reset values immediately on rst.
